escaner_teclado_4x4: RTL and testbench



---
 rtl/escaner_teclado_4x4.sv | 168 ++++++++++++++++
 tb/tb_escaner_teclado_4x4.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/escaner_teclado_4x4.sv
// ============================================================================
// Module  : escaner_teclado_4x4
// Brief   : 4x4 matrix keypad scanner with per-tick debounce and a 4-code
//           history register for a 4-digit display.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module escaner_teclado_4x4 #(
  parameter int DIV     = 100000,
  parameter int DEB_CNT = 4
) (
  input  logic        i_Reloj,
  input  logic        i_Reset,
  input  logic [3:0]  i_Columnas,
  output logic [3:0]  o_Filas,
  output logic [3:0]  o_Tecla,
  output logic        o_Valida,
  output logic        o_Presionada,
  output logic [15:0] o_Digitos
);

  localparam int c_DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int c_CNT_W = $clog2(DEB_CNT + 1);
  localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(DIV - 1);
  localparam logic [c_CNT_W-1:0] c_DEB     = c_CNT_W'(DEB_CNT);
  localparam logic [c_CNT_W-1:0] c_UNO     = c_CNT_W'(1);

  typedef enum logic [1:0] {
    ESCANEO    = 2'd0,
    REBOTE     = 2'd1,
    PRESIONADA = 2'd2,
    LIBERACION = 2'd3
  } estado_t;

  estado_t            r_estado, w_estado_sig;
  logic [3:0]         r_sync1, r_sync2;
  logic [c_DIV_W-1:0] r_div;
  logic [1:0]         r_fila, w_fila_sig;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_sig, w_cnt_inc;
  logic [3:0]         r_cand, w_cand_sig;
  logic [3:0]         r_tecla;
  logic               r_valida, r_presionada;
  logic [15:0]        r_digitos;
  logic               w_tick, w_col_low, w_aceptar, w_soltar;
  logic [1:0]         w_col_idx;

  assign w_tick    = (r_div == c_DIV_MAX);
  assign w_col_low = (r_sync2 != 4'hF);
  assign w_cnt_inc = (r_cnt >= c_DEB) ? c_DEB : r_cnt + c_UNO;

  // Lowest-numbered low column wins when several are pressed together.
  always_comb begin
    casez (r_sync2)
      4'b???0: w_col_idx = 2'd0;
      4'b??01: w_col_idx = 2'd1;
      4'b?011: w_col_idx = 2'd2;
      default: w_col_idx = 2'd3;
    endcase
  end

  always_comb begin
    w_estado_sig = r_estado;
    w_cnt_sig    = r_cnt;
    w_fila_sig   = r_fila;
    w_cand_sig   = r_cand;
    w_aceptar    = 1'b0;
    w_soltar     = 1'b0;
    if (w_tick) begin
      case (r_estado)
        ESCANEO: begin
          if (w_col_low) begin
            w_cand_sig = {r_fila, w_col_idx};
            w_cnt_sig  = c_UNO;
            if (DEB_CNT == 1) begin
              w_aceptar    = 1'b1;
              w_estado_sig = PRESIONADA;
            end else begin
              w_estado_sig = REBOTE;
            end
          end else begin
            w_fila_sig = r_fila + 2'd1;
          end
        end
        REBOTE: begin
          if (w_col_low && (w_col_idx == r_cand[1:0])) begin
            w_cnt_sig = w_cnt_inc;
            if (w_cnt_inc == c_DEB) begin
              w_aceptar    = 1'b1;
              w_estado_sig = PRESIONADA;
            end
          end else begin
            w_estado_sig = ESCANEO;
            w_fila_sig   = r_fila + 2'd1;
          end
        end
        PRESIONADA: begin
          if (!w_col_low) begin
            w_cnt_sig = c_UNO;
            if (DEB_CNT == 1) begin
              w_soltar     = 1'b1;
              w_estado_sig = ESCANEO;
              w_fila_sig   = r_fila + 2'd1;
            end else begin
              w_estado_sig = LIBERACION;
            end
          end
        end
        default: begin
          if (w_col_low) begin
            w_estado_sig = PRESIONADA;
          end else begin
            w_cnt_sig = w_cnt_inc;
            if (w_cnt_inc == c_DEB) begin
              w_soltar     = 1'b1;
              w_estado_sig = ESCANEO;
              w_fila_sig   = r_fila + 2'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_Reloj) begin
    if (!i_Reset) r_estado <= ESCANEO;
    else          r_estado <= w_estado_sig;
  end

  always_ff @(posedge i_Reloj) begin
    if (!i_Reset) begin
      r_sync1      <= 4'hF;
      r_sync2      <= 4'hF;
      r_div        <= '0;
      r_fila       <= 2'd0;
      r_cnt        <= '0;
      r_cand       <= 4'h0;
      r_tecla      <= 4'h0;
      r_valida     <= 1'b0;
      r_presionada <= 1'b0;
      r_digitos    <= 16'h0000;
    end else begin
      r_sync1  <= i_Columnas;
      r_sync2  <= r_sync1;
      r_div    <= w_tick ? '0 : r_div + c_DIV_W'(1);
      r_fila   <= w_fila_sig;
      r_cnt    <= w_cnt_sig;
      r_cand   <= w_cand_sig;
      r_valida <= w_aceptar;
      if (w_aceptar) begin
        r_tecla      <= w_cand_sig;
        r_presionada <= 1'b1;
        r_digitos    <= {r_digitos[11:0], w_cand_sig};
      end else if (w_soltar) begin
        r_presionada <= 1'b0;
      end
    end
  end

  assign o_Filas      = ~(4'b0001 << r_fila);
  assign o_Tecla      = r_tecla;
  assign o_Valida     = r_valida;
  assign o_Presionada = r_presionada;
  assign o_Digitos    = r_digitos;

endmodule

`default_nettype wire

// File: tb/tb_escaner_teclado_4x4.sv
// ============================================================================
// Module  : tb_escaner_teclado_4x4
// Brief   : Directed bench for escaner_teclado_4x4 with a behavioural keypad.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_escaner_teclado_4x4;

  localparam int DIV     = 4;
  localparam int DEB_CNT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  columnas;
  logic [3:0]  filas;
  logic [3:0]  tecla;
  logic        valida;
  logic        presionada;
  logic [15:0] digitos;
  logic [15:0] mask;

  int checks = 0;
  int failures = 0;
  int valid_cycles = 0;
  int filas_bad = 0;
  bit ok;
  logic [3:0] exp_f;

  escaner_teclado_4x4 #(.DIV(DIV), .DEB_CNT(DEB_CNT)) dut (
    .i_Reloj      (clk),
    .i_Reset      (rst_n),
    .i_Columnas   (columnas),
    .o_Filas      (filas),
    .o_Tecla      (tecla),
    .o_Valida     (valida),
    .o_Presionada (presionada),
    .o_Digitos    (digitos)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key shorts its column low while its row is driven low.
  always_comb begin
    columnas = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mask[r*4+c] && !filas[r]) columnas[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (valida === 1'b1) valid_cycles++;
    if (!(filas inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) filas_bad++;
  end

  task automatic ciclo();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic esperar_valida(input int limite, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < limite; i++) begin
      ciclo();
      if (valida === 1'b1) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  task automatic esperar_suelta(input int limite, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < limite; i++) begin
      ciclo();
      if (presionada === 1'b0) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  task automatic esperar_filas(input logic [3:0] f, input int limite, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < limite; i++) begin
      ciclo();
      if (filas === f) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulsar(input int k, input string tag, input logic [15:0] dig_exp);
    mask = 16'h0;
    mask[k] = 1'b1;
    esperar_valida(80, ok);
    check({tag, "_valida"}, 16'(ok), 16'd1);
    check({tag, "_tecla"}, 16'(tecla), 16'(k));
    check({tag, "_presionada"}, 16'(presionada), 16'd1);
    check({tag, "_digitos"}, digitos, dig_exp);
    mask = 16'h0;
    esperar_suelta(60, ok);
    check({tag, "_suelta"}, 16'(ok), 16'd1);
  endtask

  initial begin
    mask  = 16'h0;
    rst_n = 1'b0;
    repeat (3) ciclo();
    check("rst_filas", 16'(filas), 16'h000E);
    check("rst_tecla", 16'(tecla), 16'h0);
    check("rst_valida", 16'(valida), 16'h0);
    check("rst_presionada", 16'(presionada), 16'h0);
    check("rst_digitos", digitos, 16'h0000);

    // Idle scan: first tick lands DIV cycles after reset release.
    rst_n = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      ciclo();
      exp_f = ~(4'b0001 << ((k / 4) % 4));
      check("idle_filas", 16'(filas), 16'(exp_f));
    end
    check("idle_no_valida", 16'(valid_cycles), 16'd0);

    // Key 6 held; row must stay frozen while pressed.
    mask[6] = 1'b1;
    esperar_valida(60, ok);
    check("k6_valida", 16'(ok), 16'd1);
    check("k6_tecla", 16'(tecla), 16'h6);
    check("k6_presionada", 16'(presionada), 16'd1);
    check("k6_digitos", digitos, 16'h0006);
    check("k6_filas", 16'(filas), 16'hD);
    repeat (20) ciclo();
    check("k6_filas_frozen", 16'(filas), 16'hD);
    check("k6_presionada_hold", 16'(presionada), 16'd1);
    check("k6_one_pulse", 16'(valid_cycles), 16'd1);
    mask = 16'h0;
    esperar_suelta(60, ok);
    check("k6_suelta", 16'(ok), 16'd1);

    // Bounce: one-tick presses never reach DEB_CNT.
    for (int n = 0; n < 5; n++) begin
      mask[5] = 1'b1;
      repeat (4) ciclo();
      mask[5] = 1'b0;
      repeat (12) ciclo();
    end
    check("bounce_no_valida", 16'(valid_cycles), 16'd1);
    check("bounce_presionada", 16'(presionada), 16'd0);

    // Release glitch of one tick while key 9 is held.
    mask[9] = 1'b1;
    esperar_valida(80, ok);
    check("k9_valida", 16'(ok), 16'd1);
    check("k9_tecla", 16'(tecla), 16'h9);
    check("k9_digitos", digitos, 16'h0069);
    repeat (8) ciclo();
    mask[9] = 1'b0;
    repeat (4) ciclo();
    mask[9] = 1'b1;
    repeat (30) ciclo();
    check("glitch_presionada", 16'(presionada), 16'd1);
    check("glitch_no_pulse", 16'(valid_cycles), 16'd2);
    check("glitch_filas", 16'(filas), 16'hB);
    mask = 16'h0;
    esperar_suelta(60, ok);
    check("k9_suelta", 16'(ok), 16'd1);

    pulsar(1,  "seq1", 16'h0691);
    pulsar(2,  "seq2", 16'h6912);
    pulsar(3,  "seq3", 16'h9123);
    pulsar(10, "seqA", 16'h123A);
    check("seq_pulses", 16'(valid_cycles), 16'd6);

    // Columns 1 and 3 of row 0 together: lowest column wins.
    mask = 16'h0;
    mask[1] = 1'b1;
    mask[3] = 1'b1;
    esperar_valida(80, ok);
    check("simul_valida", 16'(ok), 16'd1);
    check("simul_tecla", 16'(tecla), 16'h1);
    check("simul_digitos", digitos, 16'h23A1);
    mask = 16'h0;
    esperar_suelta(60, ok);
    check("simul_suelta", 16'(ok), 16'd1);

    // Reset while debouncing key F on row 3.
    esperar_filas(4'b1110, 40, ok);
    check("rb_sync_row0", 16'(ok), 16'd1);
    mask[15] = 1'b1;
    esperar_filas(4'b0111, 40, ok);
    check("rb_row3", 16'(ok), 16'd1);
    repeat (6) ciclo();
    rst_n = 1'b0;
    repeat (2) ciclo();
    check("rb_rst_filas", 16'(filas), 16'hE);
    check("rb_rst_tecla", 16'(tecla), 16'h0);
    check("rb_rst_valida", 16'(valida), 16'h0);
    check("rb_rst_presionada", 16'(presionada), 16'h0);
    check("rb_rst_digitos", digitos, 16'h0000);
    check("rb_no_pulse", 16'(valid_cycles), 16'd7);
    rst_n = 1'b1;
    esperar_valida(80, ok);
    check("rb_valida", 16'(ok), 16'd1);
    check("rb_tecla", 16'(tecla), 16'hF);
    check("rb_digitos", digitos, 16'h000F);
    mask = 16'h0;
    esperar_suelta(60, ok);
    check("rb_suelta", 16'(ok), 16'd1);
    repeat (4) ciclo();

    check("total_pulses", 16'(valid_cycles), 16'd8);
    check("filas_onehot", 16'(filas_bad), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
